// File: rtl/dcache_miss_controller.sv
// Miss sequencer for the 2-way write-back data cache.
// It stalls the pipeline on a miss and refills the line from data memory.
// It replays the access into the cache with the fetched line on refill_data.
// When the cache reports a dirty victim, it writes that victim back and then
// installs the line a second time.
// This block owns the only data-memory port.
module dcache_miss_controller #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int OFFSET_BITS = 5,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cache_hit,
  input  logic                  cache_flush_done,
  input  logic [ADDR_WIDTH-1:0] cache_flush_address,
  input  logic [LINE_WIDTH-1:0] cache_flush_data,
  output logic                  cache_read_enable,
  output logic                  cache_write_enable,
  output logic [LINE_WIDTH-1:0] refill_data,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [CNT_WIDTH-1:0]  writeback_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFILL,
    S_INSTALL,
    S_CHECK,
    S_WRITEBACK
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_WIDTH-1:0] refill_data_q, refill_data_d;
  logic [CNT_WIDTH-1:0]  miss_count_q, miss_count_d;
  logic [CNT_WIDTH-1:0]  wb_count_q, wb_count_d;

  logic                  op;
  logic                  is_wr;
  logic [ADDR_WIDTH-1:0] line_addr;

  // Decode the request: a load wins when read and write are both high.
  assign op        = cpu_read | cpu_write;
  assign is_wr     = cpu_write & ~cpu_read;
  assign line_addr = {cpu_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // Next-state, register next values and the combinational cache/pipeline strobes.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
    state_d            = state_q;
    is_wr_d            = is_wr_q;
    mem_req_d          = mem_req_q;
    mem_write_d        = mem_write_q;
    mem_addr_d         = mem_addr_q;
    mem_wdata_d        = mem_wdata_q;
    refill_data_d      = refill_data_q;
    miss_count_d       = miss_count_q;
    wb_count_d         = wb_count_q;
    cache_read_enable  = 1'b0;
    cache_write_enable = 1'b0;
    stall              = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (cache_hit) begin
            cache_read_enable  = cpu_read;
            cache_write_enable = is_wr;
          end else begin
            stall       = 1'b1;
            is_wr_d     = is_wr;
            mem_req_d   = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = line_addr;
            if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + CNT_ONE;
            state_d     = S_REFILL;
          end
        end
      end

      S_REFILL: begin
        stall = 1'b1;
        if (mem_ready) begin
          refill_data_d = mem_rdata;
          mem_req_d     = 1'b0;
          state_d       = S_INSTALL;
        end
      end

      // Replays the latched access into the cache with refill_data.
      S_INSTALL: begin
        stall              = 1'b1;
        cache_read_enable  = ~is_wr_q;
        cache_write_enable = is_wr_q;
        state_d            = S_CHECK;
      end

      // The cache registers its victim report, so it is only valid here.
      S_CHECK: begin
        stall = 1'b1;
        if (!cache_flush_done) begin
          mem_req_d   = 1'b1;
          mem_write_d = 1'b1;
          mem_addr_d  = cache_flush_address;
          mem_wdata_d = cache_flush_data;
          state_d     = S_WRITEBACK;
        end else begin
          state_d = S_IDLE;
        end
      end

      // After the victim is written back, the line is installed again.
      S_WRITEBACK: begin
        stall = 1'b1;
        if (mem_ready) begin
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          if (wb_count_q != CNT_MAX) wb_count_d = wb_count_q + CNT_ONE;
          state_d     = S_INSTALL;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; an asynchronous reset aborts any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      is_wr_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      refill_data_q <= '0;
      miss_count_q  <= '0;
      wb_count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments let all registers update together from pre-edge values.
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      refill_data_q <= refill_data_d;
      miss_count_q  <= miss_count_d;
      wb_count_q    <= wb_count_d;
    end
  end

  assign refill_data     = refill_data_q;
  assign mem_req         = mem_req_q;
  assign mem_write       = mem_write_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign miss_count      = miss_count_q;
  assign writeback_count = wb_count_q;

endmodule

// File: tb/tb_dcache_miss_controller.sv
// Directed bench for dcache_miss_controller.
// A second instance with CNT_WIDTH=2 shares all inputs and exercises counter saturation.
module tb_dcache_miss_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_read, cpu_write, cache_hit, cache_flush_done, mem_ready;
  logic [31:0]  cpu_address, cache_flush_address;
  logic [255:0] cache_flush_data, mem_rdata;

  logic         cache_read_enable, cache_write_enable, stall, mem_req, mem_write;
  logic [255:0] refill_data, mem_wdata;
  logic [31:0]  mem_addr, miss_count, writeback_count;

  logic         s_rd_en, s_wr_en, s_stall, s_req, s_write;
  logic [255:0] s_refill, s_wdata;
  logic [31:0]  s_addr;
  logic [1:0]   s_miss_count, s_wb_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_3C = {32{8'h3C}};
  localparam logic [255:0] PAT_5A = {32{8'h5A}};
  localparam logic [255:0] PAT_11 = {32{8'h11}};

  always #5 clk = ~clk;

  dcache_miss_controller u_dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cache_hit(cache_hit), .cache_flush_done(cache_flush_done),
    .cache_flush_address(cache_flush_address), .cache_flush_data(cache_flush_data),
    .cache_read_enable(cache_read_enable), .cache_write_enable(cache_write_enable),
    .refill_data(refill_data), .stall(stall),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .miss_count(miss_count), .writeback_count(writeback_count)
  );

  dcache_miss_controller #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cache_hit(cache_hit), .cache_flush_done(cache_flush_done),
    .cache_flush_address(cache_flush_address), .cache_flush_data(cache_flush_data),
    .cache_read_enable(s_rd_en), .cache_write_enable(s_wr_en),
    .refill_data(s_refill), .stall(s_stall),
    .mem_req(s_req), .mem_write(s_write), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .miss_count(s_miss_count), .writeback_count(s_wb_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_read = 0; cpu_write = 0; cache_hit = 0; cache_flush_done = 1'b1; mem_ready = 0;
    cpu_address = '0; cache_flush_address = '0; cache_flush_data = '0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_write: got %b want 0", mem_write); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 256'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (refill_data !== 256'h0) begin n_err++; $display("FAIL rst_refill: got %h want 0", refill_data); end
    n_cmp++; if (miss_count !== 32'h0 || writeback_count !== 32'h0) begin n_err++;
      $display("FAIL rst_counters: got %0d/%0d want 0/0", miss_count, writeback_count); end
    n_cmp++; if ({stall, cache_read_enable, cache_write_enable} !== 3'b000) begin n_err++;
      $display("FAIL rst_idle_outs: got %b want 000", {stall, cache_read_enable, cache_write_enable}); end
  endtask

  task automatic test_hit();
    tick();
    cpu_read = 1; cache_hit = 1; cpu_address = 32'h0000_0100;
    #1;
    n_cmp++; if ({cache_read_enable, cache_write_enable, stall} !== 3'b100) begin n_err++;
      $display("FAIL read_hit: got %b want 100", {cache_read_enable, cache_write_enable, stall}); end
    tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL hit_no_req: got %b want 0", mem_req); end
    cpu_read = 0; cpu_write = 1;
    #1;
    n_cmp++; if ({cache_read_enable, cache_write_enable, stall} !== 3'b010) begin n_err++;
      $display("FAIL write_hit: got %b want 010", {cache_read_enable, cache_write_enable, stall}); end
    tick();
    cpu_write = 0; cache_hit = 0;
  endtask

  task automatic test_clean_miss();
    tick();
    cpu_read = 1; cache_hit = 0; cpu_address = 32'h0000_1234;
    #1;
    n_cmp++; if ({stall, cache_read_enable} !== 2'b10) begin n_err++;
      $display("FAIL miss_stall: got %b want 10", {stall, cache_read_enable}); end
    tick();
    n_cmp++; if ({mem_req, mem_write} !== 2'b10) begin n_err++;
      $display("FAIL refill_req: got %b want 10", {mem_req, mem_write}); end
    n_cmp++; if (mem_addr !== 32'h0000_1220) begin n_err++;
      $display("FAIL refill_addr: got %h want 00001220", mem_addr); end
    n_cmp++; if (miss_count !== 32'd1) begin n_err++; $display("FAIL miss_cnt1: got %0d want 1", miss_count); end
    cpu_address = 32'hFFFF_FFE0;   // may change while stalled
    tick(); tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1220 || stall !== 1'b1) begin n_err++;
      $display("FAIL refill_hold: got req=%b addr=%h stall=%b want 1/00001220/1", mem_req, mem_addr, stall); end
    mem_ready = 1; mem_rdata = PAT_A5;
    tick();
    mem_ready = 0; mem_rdata = '0;
    #1;
    n_cmp++; if (refill_data !== PAT_A5) begin n_err++; $display("FAIL refill_data: got %h want %h", refill_data, PAT_A5); end
    n_cmp++; if ({mem_req, stall, cache_read_enable, cache_write_enable} !== 4'b0110) begin n_err++;
      $display("FAIL install_rd: got %b want 0110", {mem_req, stall, cache_read_enable, cache_write_enable}); end
    tick();
    n_cmp++; if ({stall, cache_read_enable, cache_write_enable} !== 3'b100) begin n_err++;
      $display("FAIL check_clean: got %b want 100", {stall, cache_read_enable, cache_write_enable}); end
    tick();
    cpu_address = 32'h0000_1234; cache_hit = 1;
    #1;
    n_cmp++; if ({stall, cache_read_enable} !== 2'b01) begin n_err++;
      $display("FAIL replay_hit: got %b want 01", {stall, cache_read_enable}); end
    n_cmp++; if (miss_count !== 32'd1 || writeback_count !== 32'd0) begin n_err++;
      $display("FAIL clean_counts: got %0d/%0d want 1/0", miss_count, writeback_count); end
    tick();
    cpu_read = 0; cache_hit = 0;
  endtask

  task automatic test_dirty_miss();
    tick();
    cpu_write = 1; cache_hit = 0; cpu_address = 32'h0000_4567;
    tick();
    n_cmp++; if (mem_addr !== 32'h0000_4560 || mem_write !== 1'b0) begin n_err++;
      $display("FAIL dirty_refill_addr: got %h/%b want 00004560/0", mem_addr, mem_write); end
    mem_ready = 1; mem_rdata = PAT_3C;
    tick();
    mem_ready = 0;
    #1;
    n_cmp++; if ({cache_read_enable, cache_write_enable} !== 2'b01 || refill_data !== PAT_3C) begin n_err++;
      $display("FAIL install_wr1: got %b data=%h want 01", {cache_read_enable, cache_write_enable}, refill_data); end
    cache_flush_done = 0; cache_flush_address = 32'h0000_4000; cache_flush_data = PAT_5A;
    tick();
    n_cmp++; if ({mem_req, stall, cache_write_enable} !== 3'b010) begin n_err++;
      $display("FAIL check_dirty: got %b want 010", {mem_req, stall, cache_write_enable}); end
    tick();
    cache_flush_done = 1; cache_flush_address = '0; cache_flush_data = '0;
    #1;
    n_cmp++; if ({mem_req, mem_write} !== 2'b11 || mem_addr !== 32'h0000_4000) begin n_err++;
      $display("FAIL wb_req: got %b addr=%h want 11/00004000", {mem_req, mem_write}, mem_addr); end
    n_cmp++; if (mem_wdata !== PAT_5A) begin n_err++; $display("FAIL wb_data: got %h want %h", mem_wdata, PAT_5A); end
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_wdata !== PAT_5A || writeback_count !== 32'd0) begin n_err++;
      $display("FAIL wb_hold: got req=%b wbc=%0d want 1/0", mem_req, writeback_count); end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    #1;
    n_cmp++; if ({mem_req, mem_write} !== 2'b00 || writeback_count !== 32'd1) begin n_err++;
      $display("FAIL wb_done: got %b wbc=%0d want 00/1", {mem_req, mem_write}, writeback_count); end
    n_cmp++; if ({stall, cache_read_enable, cache_write_enable} !== 3'b101) begin n_err++;
      $display("FAIL install_wr2: got %b want 101", {stall, cache_read_enable, cache_write_enable}); end
    tick(); tick();
    cache_hit = 1;
    #1;
    n_cmp++; if ({stall, cache_write_enable} !== 2'b01 || miss_count !== 32'd2) begin n_err++;
      $display("FAIL dirty_replay: got %b miss=%0d want 01/2", {stall, cache_write_enable}, miss_count); end
    tick();
    cpu_write = 0; cache_hit = 0;
  endtask

  task automatic test_reset_mid();
    tick();
    cpu_read = 1; cache_hit = 0; cpu_address = 32'h0000_8000;
    tick();
    cpu_read = 0;
    #1;
    n_cmp++; if (mem_req !== 1'b1 || stall !== 1'b1) begin n_err++;
      $display("FAIL pre_abort: got req=%b stall=%b want 1/1", mem_req, stall); end
    #2 reset = 1;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_err++;
      $display("FAIL abort_idle: got req=%b stall=%b want 0/0", mem_req, stall); end
    n_cmp++; if (miss_count !== 32'd0 || mem_addr !== 32'h0) begin n_err++;
      $display("FAIL abort_clear: got miss=%0d addr=%h want 0/0", miss_count, mem_addr); end
    tick();
    reset = 0;
  endtask

  task automatic test_read_write_miss();
    tick();
    cpu_read = 1; cpu_write = 1; cache_hit = 0; cpu_address = 32'h0000_0020;
    tick();
    mem_ready = 1; mem_rdata = PAT_11;
    tick();
    mem_ready = 0; mem_rdata = '0;
    #1;
    n_cmp++; if ({cache_read_enable, cache_write_enable} !== 2'b10) begin n_err++;
      $display("FAIL rw_install: got %b want 10", {cache_read_enable, cache_write_enable}); end
    tick(); tick();
    cpu_read = 0; cpu_write = 0;
    mem_ready = 1; mem_rdata = PAT_A5;
    tick();
    mem_ready = 0; mem_rdata = '0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0 || refill_data !== PAT_11) begin n_err++;
      $display("FAIL idle_ready_ignored: got req=%b stall=%b data=%h", mem_req, stall, refill_data); end
    n_cmp++; if (miss_count !== 32'd1) begin n_err++; $display("FAIL rw_miss_cnt: got %0d want 1", miss_count); end
  endtask

  task automatic do_clean_miss(input logic [31:0] addr);
    tick();
    cpu_read = 1; cache_hit = 0; cpu_address = addr;
    tick();
    mem_ready = 1; mem_rdata = PAT_A5;
    tick();
    mem_ready = 0;
    tick(); tick();
    cpu_read = 0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat;
    tick();
    reset = 1;
    tick();
    reset = 0;
    for (int k = 1; k <= 5; k++) begin
      do_clean_miss(32'h0000_1000 + 32'(k) * 32'h40);
      exp_sat = (k >= 3) ? 2'd3 : 2'(k);
      #1;
      n_cmp++; if (s_miss_count !== exp_sat) begin n_err++;
        $display("FAIL sat_miss_%0d: got %0d want %0d", k, s_miss_count, exp_sat); end
      n_cmp++; if (miss_count !== 32'(k)) begin n_err++;
        $display("FAIL wide_miss_%0d: got %0d want %0d", k, miss_count, k); end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid();
    test_read_write_miss();
    test_saturation();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
